// File: rtl/axil_reg_slave.sv
// axil_reg_slave: single-clock AXI4-lite responder with a bank of REG_COUNT R/W registers.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*       AXI-lite write channels (awprot ignored)
//   s_axil_ar*/r*          AXI-lite read channels (arprot ignored)
//   reg_out_o              flat register view, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_o               one-cycle pulse per register on a committed write with any strobe set
//
// AW and W are captured independently. The write commits on the edge after both are held,
// so a same-cycle AW+W on edge N shows bvalid/reg_wr/register update after edge N+1.
// Bad addresses answer SLVERR with no register side effect.
module axil_reg_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned REG_COUNT  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr_i,
  input  logic [2:0]                      s_axil_awprot_i,
  input  logic                            s_axil_awvalid_i,
  output logic                            s_axil_awready_o,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata_i,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb_i,
  input  logic                            s_axil_wvalid_i,
  output logic                            s_axil_wready_o,
  output logic [1:0]                      s_axil_bresp_o,
  output logic                            s_axil_bvalid_o,
  input  logic                            s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr_i,
  input  logic [2:0]                      s_axil_arprot_i,
  input  logic                            s_axil_arvalid_i,
  output logic                            s_axil_arready_o,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata_o,
  output logic [1:0]                      s_axil_rresp_o,
  output logic                            s_axil_rvalid_o,
  input  logic                            s_axil_rready_i,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out_o,
  output logic [REG_COUNT-1:0]            reg_wr_o
);

  localparam int unsigned IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned HI_LSB   = ADDR_LSB + IDX_W;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Valid iff index is in range and every bit above the index field is zero.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] hi;
    idx = a[ADDR_LSB +: IDX_W];
    hi  = a >> HI_LSB;
    return (32'(idx) < REG_COUNT) && (hi == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  logic                  aw_held_q, aw_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [REG_COUNT-1:0]  reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign s_axil_awready_o = !aw_held_q && !bvalid_q;
  assign s_axil_wready_o  = !w_held_q && !bvalid_q;
  assign s_axil_arready_o = !rvalid_q;

  assign aw_hs  = s_axil_awvalid_i && s_axil_awready_o;
  assign w_hs   = s_axil_wvalid_i && s_axil_wready_o;
  assign ar_hs  = s_axil_arvalid_i && s_axil_arready_o;
  assign commit = aw_held_q && w_held_q;

  assign wr_ok  = addr_ok(aw_addr_q);
  assign wr_idx = addr_idx(aw_addr_q);
  assign rd_ok  = addr_ok(s_axil_araddr_i);
  assign rd_idx = addr_idx(s_axil_araddr_i);

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    reg_wr_d  = '0;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axil_awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axil_wdata_i;
      w_strb_d = s_axil_wstrb_i;
    end
    if (bvalid_q && s_axil_bready_i) begin
      bvalid_d = 1'b0;
    end
    // Commit cannot coincide with a new AW/W capture or a B handshake: readies
    // are low while held or while bvalid is up.
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RespOkay : RespSlverr;
      if (wr_ok) begin
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
          if (w_strb_q[b]) begin
            regs_d[wr_idx][8*b +: 8] = w_data_q[8*b +: 8];
          end
        end
        reg_wr_d[wr_idx] = |w_strb_q;
      end
    end
  end

  // Reads sample regs_q, so a same-edge write commit is not visible to this read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready_i) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? regs_q[rd_idx] : '0;
      rresp_d  = rd_ok ? RespOkay : RespSlverr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      reg_wr_q  <= '0;
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      reg_wr_q  <= reg_wr_d;
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s_axil_bvalid_o = bvalid_q;
  assign s_axil_bresp_o  = bresp_q;
  assign s_axil_rvalid_o = rvalid_q;
  assign s_axil_rdata_o  = rdata_q;
  assign s_axil_rresp_o  = rresp_q;
  assign reg_wr_o        = reg_wr_q;

  for (genvar g = 0; g < int'(REG_COUNT); g++) begin : g_reg_out
    assign reg_out_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // Protection bits carry no meaning for this register bank.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot_i, s_axil_arprot_i};

endmodule

// File: tb/tb_axil_reg_slave.sv
module tb_axil_reg_slave;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [255:0] reg_out;
  logic [7:0]   reg_wr;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [8];

  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, wr_pulses = 0;

  always #5 clk_i = ~clk_i;

  axil_reg_slave dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .s_axil_awaddr_i  (awaddr),
    .s_axil_awprot_i  (3'b000),
    .s_axil_awvalid_i (awvalid),
    .s_axil_awready_o (awready),
    .s_axil_wdata_i   (wdata),
    .s_axil_wstrb_i   (wstrb),
    .s_axil_wvalid_i  (wvalid),
    .s_axil_wready_o  (wready),
    .s_axil_bresp_o   (bresp),
    .s_axil_bvalid_o  (bvalid),
    .s_axil_bready_i  (bready),
    .s_axil_araddr_i  (araddr),
    .s_axil_arprot_i  (3'b000),
    .s_axil_arvalid_i (arvalid),
    .s_axil_arready_o (arready),
    .s_axil_rdata_o   (rdata),
    .s_axil_rresp_o   (rresp),
    .s_axil_rvalid_o  (rvalid),
    .s_axil_rready_i  (rready),
    .reg_out_o        (reg_out),
    .reg_wr_o         (reg_wr)
  );

  // Handshake monitor: counts each accepted beat exactly once.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      if (awvalid && awready) aw_cnt++;
      if (wvalid && wready) w_cnt++;
      if (bvalid && bready) b_cnt++;
      if (arvalid && arready) ar_cnt++;
      if (rvalid && rready) r_cnt++;
      wr_pulses += $countones(reg_wr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = mdl[i];
    return p;
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int adly, input int wdly, input int bst,
                           input logic [1:0] exp_resp);
    logic aok, wok, bok;
    aok = 1'b0;
    wok = 1'b0;
    bok = 1'b0;
    fork
      begin
        repeat (adly) tick();
        awaddr  = a;
        awvalid = 1'b1;
        for (int k = 0; k < 50 && !aok; k++) begin
          aok = awready;
          tick();
        end
        awvalid = 1'b0;
      end
      begin
        repeat (wdly) tick();
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int k = 0; k < 50 && !wok; k++) begin
          wok = wready;
          tick();
        end
        wvalid = 1'b0;
      end
    join
    chk("aw accepted", aok, 1);
    chk("w accepted", wok, 1);
    for (int k = 0; k < 50 && !bok; k++) begin
      if (bvalid) bok = 1'b1;
      else tick();
    end
    chk("b seen", bok, 1);
    chk("bresp", bresp, exp_resp);
    repeat (bst) begin
      tick();
      chk("b held", {bvalid, bresp}, {1'b1, exp_resp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b cleared", bvalid, 0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int ardly, input int rst_cyc,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic aok, rok;
    aok = 1'b0;
    rok = 1'b0;
    repeat (ardly) tick();
    araddr  = a;
    arvalid = 1'b1;
    for (int k = 0; k < 50 && !aok; k++) begin
      aok = arready;
      tick();
    end
    arvalid = 1'b0;
    chk("ar accepted", aok, 1);
    for (int k = 0; k < 50 && !rok; k++) begin
      if (rvalid) rok = 1'b1;
      else tick();
    end
    chk("r seen", rok, 1);
    chk("r data/resp", {rdata, rresp}, {exp_data, exp_resp});
    repeat (rst_cyc) begin
      tick();
      chk("r held", {rvalid, rdata, rresp}, {1'b1, exp_data, exp_resp});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("r cleared", rvalid, 0);
  endtask

  initial begin
    int base_aw, base_w, base_b, base_ar, base_r, base_wr, exp_wr;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    // Reset state, including readies high while reset is asserted.
    #12;
    chk("rst awready", awready, 1);
    chk("rst wready", wready, 1);
    chk("rst arready", arready, 1);
    chk("rst bvalid", bvalid, 0);
    chk("rst rvalid", {rvalid, rdata, rresp, bresp}, 0);
    chk("rst reg_out", reg_out, 0);
    chk("rst reg_wr", reg_wr, 0);
    rst_ni = 1'b1;
    tick();

    // Reset while an AW is held drops it.
    awaddr  = 32'h4;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("aw held", awready, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("async rst awready", awready, 1);
    #3 rst_ni = 1'b1;
    tick();
    tick();
    chk("post rst bvalid", bvalid, 0);
    chk("post rst reg_out", reg_out, pack_model());
    chk("post rst awready", awready, 1);

    // AW and W in the same cycle; B held under bready=0.
    awaddr = 32'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t2 bvalid early", {bvalid, reg_wr}, 0);
    tick();
    mdl[1] = 32'hDEADBEEF;
    chk("t2 bvalid", bvalid, 1);
    chk("t2 bresp", bresp, 2'b00);
    chk("t2 reg_wr", reg_wr, 8'h02);
    chk("t2 reg_out", reg_out, pack_model());
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2 b stable", {bvalid, bresp, reg_wr}, {1'b1, 2'b00, 8'h00});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t2 b done", bvalid, 0);

    // W three cycles ahead of AW, partial strobe.
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t3 wready low", {wready, awready}, 2'b01);
    tick();
    tick();
    chk("t3 still waiting", {wready, bvalid}, 2'b00);
    awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    mdl[2] = 32'h00005678;
    chk("t3 commit", {bvalid, bresp, reg_wr, wready}, {1'b1, 2'b00, 8'h04, 1'b0});
    chk("t3 reg_out", reg_out, pack_model());
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t3 wready back", {wready, bvalid}, 2'b10);

    // Out-of-range write and read.
    awaddr = 32'h20; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t4 bad write", {bvalid, bresp, reg_wr}, {1'b1, 2'b10, 8'h00});
    chk("t4 no change", reg_out, pack_model());
    bready = 1'b1;
    tick();
    bready = 1'b0;
    araddr = 32'h1000_0000; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t4 bad read", {rvalid, rresp, rdata, arready}, {1'b1, 2'b10, 32'h0, 1'b0});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("t4 r done", {rvalid, arready}, 2'b01);

    // Read capture and write commit on the same edge return the old value.
    awaddr = 32'h4; wdata = 32'hAAAA5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h4; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    mdl[1] = 32'hAAAA5555;
    chk("t5 old data", {rvalid, rdata, rresp}, {1'b1, 32'hDEADBEEF, 2'b00});
    chk("t5 commit", {bvalid, reg_wr}, {1'b1, 8'h02});
    chk("t5 reg_out", reg_out, pack_model());
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h4, 0, 0, 32'hAAAA5555, 2'b00);

    // Randomised concurrent traffic against the register model.
    base_aw = aw_cnt; base_w = w_cnt; base_b = b_cnt;
    base_ar = ar_cnt; base_r = r_cnt; base_wr = wr_pulses;
    exp_wr = 0;
    for (int it = 0; it < 40; it++) begin
      int widx, ridx;
      logic wbad, rbad;
      logic [31:0] wa, ra, wd, er;
      logic [3:0] ws;
      widx = int'($urandom_range(0, 7));
      ridx = (widx + 1 + int'($urandom_range(0, 6))) % 8;
      wbad = ($urandom_range(0, 5) == 0);
      rbad = ($urandom_range(0, 5) == 0);
      wa = wbad ? (($urandom_range(0, 1) == 1) ? 32'h20 + 32'(widx) * 4
                                                 : 32'h8000_0000 | (32'(widx) * 4))
                : 32'(widx) * 4 + $urandom_range(0, 3);
      ra = rbad ? 32'h40 + 32'(ridx) * 4 : 32'(ridx) * 4 + $urandom_range(0, 3);
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      er = rbad ? 32'h0 : mdl[ridx];
      fork
        axi_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), wbad ? 2'b10 : 2'b00);
        axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), er,
                 rbad ? 2'b10 : 2'b00);
      join
      if (!wbad) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) mdl[widx][8*b +: 8] = wd[8*b +: 8];
        end
        if (ws != 4'h0) exp_wr++;
      end
    end
    tick();
    chk("rand reg_out", reg_out, pack_model());
    chk("rand aw count", aw_cnt - base_aw, 40);
    chk("rand w count", w_cnt - base_w, 40);
    chk("rand b count", b_cnt - base_b, 40);
    chk("rand ar count", ar_cnt - base_ar, 40);
    chk("rand r count", r_cnt - base_r, 40);
    chk("rand reg_wr pulses", wr_pulses - base_wr, exp_wr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
